mem_arbiter: RTL

Shares the single-ported unified memory between the instruction-fetch stage (IF) and the load/store path of the MEM stage (DM), one transaction outstanding at a time. Data requests normally win over fetches, and a starvation guard bounds how long a fetch can be held off. The block sits between the pipeline's fetch/memory stages and the memory model. The pipeline stalls on the absence of `if_gnt`/`dm_gnt`.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Types shared by the unified-memory arbiter and its neighbours.
// Holds the arbiter state encoding and the memory request payload struct.
// Payload widths match the default 32-bit address/data configuration.
package common;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_IF,
    ARB_BUSY_DM
  } mem_arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
  } mem_req_type;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (IF) and load/store (DM).
// Latency: grant is combinational from IDLE; completion follows memory rvalid.
// Backpressure: requesters are held off by withholding gnt; one access outstanding.
module mem_arbiter
  import common::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic                    dm_gnt,
  output logic                    dm_rvalid,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  mem_arb_state_t state;
  logic [CW-1:0]  starve_cnt;
  logic           idle;
  logic           starved;
  mem_req_type    if_pl;
  mem_req_type    dm_pl;
  mem_req_type    mem_pl;

  // Grant decision: only from IDLE, DM preferred unless IF has been starved.
  always_comb begin
    idle    = !reset && (state == ARB_IDLE);
    starved = (starve_cnt == LIMIT);
    if_gnt  = idle && if_req && (!dm_req || starved);
    dm_gnt  = idle && dm_req && !(if_req && starved);
    mem_req = if_gnt || dm_gnt;
  end

  // Payload mux: winner's payload while granting, all-zero otherwise.
  always_comb begin
    if_pl       = '0;
    if_pl.we    = 1'b0;
    if_pl.addr  = if_addr;
    if_pl.be    = '1;
    dm_pl.we    = dm_we;
    dm_pl.addr  = dm_addr;
    dm_pl.wdata = dm_wdata;
    dm_pl.be    = dm_be;
    mem_pl      = '0;
    if (if_gnt) begin
      mem_pl = if_pl;
    end else if (dm_gnt) begin
      mem_pl = dm_pl;
    end
    mem_we    = mem_pl.we;
    mem_addr  = mem_pl.addr;
    mem_wdata = mem_pl.wdata;
    mem_be    = mem_pl.be;
  end

  // Completion routing: rvalid goes to whichever side owns the access; a
  // completion seen in IDLE (spurious, or orphaned by reset) is dropped.
  always_comb begin
    if_rvalid = !reset && (state == ARB_BUSY_IF) && mem_rvalid;
    dm_rvalid = !reset && (state == ARB_BUSY_DM) && mem_rvalid;
    if_rdata  = mem_rdata;
    dm_rdata  = mem_rdata;
  end

  // Transaction FSM: no grant in the completion cycle, so BUSY always returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (if_gnt) begin
            state <= ARB_BUSY_IF;
          end else if (dm_gnt) begin
            state <= ARB_BUSY_DM;
          end
        end
        ARB_BUSY_IF, ARB_BUSY_DM: begin
          if (mem_rvalid) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Starvation guard: count DM wins over a waiting fetch, saturate, clear on IF win.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (dm_gnt && if_req && !starved) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule
